// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-address sprite ROM among several renderers.
// Grants are combinational; the response comes back one cycle later, tagged with the requester index.
module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned ROW_W   = 1,
    parameter int unsigned COL_W   = 1,
    parameter int unsigned DATA_W  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pause,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ROW_W-1:0]   req_row,
    input  logic [NUM_REQ*COL_W-1:0]   req_col,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [ROW_W-1:0]           rom_row,
    output logic [COL_W-1:0]           rom_col,
    input  logic [DATA_W-1:0]          rom_data,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DATA_W-1:0]          rsp_data
);

    localparam int unsigned SUM_W = ID_W + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] req_rot;
    logic               found;
    logic [ID_W-1:0]    offset;
    logic [ID_W-1:0]    winner;
    logic               grant;

    // Modular add of two in-range indices; a single subtract suffices since a+b < 2*NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a,
                                                 input logic [ID_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s >= SUM_W'(NUM_REQ)) begin
            s = s - SUM_W'(NUM_REQ);
        end
        return s[ID_W-1:0];
    endfunction

    // Rotate requests so the highest-priority index sits at bit 0.
    always_comb begin
        req_rot = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            req_rot[j] = req[wrap_add(rr_ptr, ID_W'(j))];
        end
    end

    // Fixed-priority encoder on the rotated vector: lowest set bit wins.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                found  = 1'b1;
                offset = ID_W'(j);
            end
        end
    end

    assign winner = wrap_add(rr_ptr, offset);
    assign grant  = found && !pause && !reset;

    // One-hot grant and ROM address mux; idle address is zero.
    always_comb begin
        gnt     = '0;
        rom_row = '0;
        rom_col = '0;
        if (grant) begin
            gnt[winner] = 1'b1;
            rom_row     = req_row[int'(winner) * int'(ROW_W) +: ROW_W];
            rom_col     = req_col[int'(winner) * int'(COL_W) +: COL_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= grant;
            if (grant) begin
                rr_ptr <= wrap_add(winner, ID_W'(1));
                rsp_id <= winner;
            end
        end
    end

    // ROM output already lines up with rsp_valid because the ROM registers its address.
    assign rsp_data = rom_data;

endmodule
